fetch_queue: RTL and testbench

Instruction fetch stage that feeds the CPU decode stage. It owns the program counter and drives the asynchronous instruction memory address. Fetched words go into a DEPTH-entry prefetch FIFO. Decode consumes words through a valid/ready handshake, so decode stalls no longer freeze the PC, and a fetched HALT opcode stops fetching.

---
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 97 +++++++++
 tb/tb_fetch_queue.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_queue_if : fetch-stage bus (imem, control, decode side), rev 1.0
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int BUS_WIDTH = 32,
  parameter int PTR_W     = 2
);
  logic [BUS_WIDTH-1:0] imem_addr;
  logic [BUS_WIDTH-1:0] imem_data;
  logic                 PCEn;
  logic                 flush;
  logic [BUS_WIDTH-1:0] flush_pc;
  logic [BUS_WIDTH-1:0] instr_out;
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 halted;
  logic [PTR_W:0]       count;
  logic [BUS_WIDTH-1:0] fetch_cnt;

  modport master (
    output imem_addr, instr_out, instr_valid, halted, count, fetch_cnt,
    input  imem_data, PCEn, flush, flush_pc, instr_ready
  );

  modport slave (
    input  imem_addr, instr_out, instr_valid, halted, count, fetch_cnt,
    output imem_data, PCEn, flush, flush_pc, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_queue : PC owner + DEPTH-entry prefetch FIFO feeding decode, rev 1.0
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int         BUS_WIDTH = 32,
  parameter int         DEPTH     = 4,
  parameter int         PTR_W     = 2,
  parameter logic [3:0] HALT_OP   = 4'hF
) (
  input  wire logic      CLK,
  input  wire logic      RSTn,
  fetch_queue_if.master  bus
);

  localparam logic [PTR_W:0]       C_DEPTH  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]       C_CNT1   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]     C_PTR1   = PTR_W'(1);
  localparam logic [BUS_WIDTH-1:0] C_WORD1  = BUS_WIDTH'(1);

  logic [BUS_WIDTH-1:0] storage_q [DEPTH];
  logic [BUS_WIDTH-1:0] pc_q, pc_d;
  logic [BUS_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 halted_q, halted_d;

  logic w_valid, w_pop, w_push, w_is_halt;

  assign w_valid   = (count_q != '0);
  assign w_pop     = w_valid & bus.instr_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push    = bus.PCEn & ~halted_q & ~bus.flush & ((count_q != C_DEPTH) | w_pop);
  assign w_is_halt = (bus.imem_data[BUS_WIDTH-1 -: 4] == HALT_OP);

  always_comb begin
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    halted_d    = halted_q;
    if (bus.flush) begin
      pc_d     = bus.flush_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      halted_d = 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_d    = wr_ptr_q + C_PTR1;
        pc_d        = pc_q + C_WORD1;
        fetch_cnt_d = fetch_cnt_q + C_WORD1;
        if (w_is_halt) halted_d = 1'b1;
      end
      if (w_pop) rd_ptr_d = rd_ptr_q + C_PTR1;
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + C_CNT1;
        2'b01:   count_d = count_q - C_CNT1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      pc_q        <= '0;
      fetch_cnt_q <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      halted_q    <= halted_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge CLK) begin
    if (w_push) storage_q[wr_ptr_q] <= bus.imem_data;
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = w_valid;
  assign bus.instr_out   = w_valid ? storage_q[rd_ptr_q] : '0;
  assign bus.halted      = halted_q;
  assign bus.count       = count_q;
  assign bus.fetch_cnt   = fetch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_queue : directed self-checking bench for fetch_queue, rev 1.0
// ---------------------------------------------------------------------------
module tb_fetch_queue;

  localparam logic [31:0] C_BASE = 32'h1000_0000;

  logic CLK;
  logic RSTn;
  logic [31:0] mem [256];
  int n_checks;
  int n_fail;

  fetch_queue_if #(.BUS_WIDTH(32), .PTR_W(2)) bus ();

  fetch_queue #(
    .BUS_WIDTH(32), .DEPTH(4), .PTR_W(2), .HALT_OP(4'hF)
  ) u_dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus.master)
  );

  assign bus.imem_data = mem[bus.imem_addr[7:0]];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    step(1);
    RSTn = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = C_BASE + i;
    RSTn            = 1'b0;
    bus.PCEn        = 1'b0;
    bus.flush       = 1'b0;
    bus.flush_pc    = '0;
    bus.instr_ready = 1'b0;
    step(2);

    chk("rst_pc",      bus.imem_addr, 32'd0);
    chk("rst_count",   32'(bus.count), 32'd0);
    chk("rst_valid",   32'(bus.instr_valid), 32'd0);
    chk("rst_out",     bus.instr_out, 32'd0);
    chk("rst_halted",  32'(bus.halted), 32'd0);
    chk("rst_fcnt",    bus.fetch_cnt, 32'd0);

    // Streaming: one push and one pop per cycle
    RSTn = 1'b1; bus.PCEn = 1'b1; bus.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("stream_out",   bus.instr_out, C_BASE + k);
      chk("stream_count", 32'(bus.count), 32'd1);
      chk("stream_fcnt",  bus.fetch_cnt, 32'(k + 1));
    end
    chk("stream_pc", bus.imem_addr, 32'd4);

    // Backpressure fills the FIFO and freezes the PC
    bus.instr_ready = 1'b0;
    do_reset();
    step(4);
    chk("bp_count4", 32'(bus.count), 32'd4);
    step(6);
    chk("bp_count10", 32'(bus.count), 32'd4);
    chk("bp_pc",      bus.imem_addr, 32'd4);
    chk("bp_head",    bus.instr_out, C_BASE);
    chk("bp_fcnt",    bus.fetch_cnt, 32'd4);

    // Full FIFO with a single-cycle pop
    bus.instr_ready = 1'b1;
    step(1);
    bus.instr_ready = 1'b0;
    chk("fullpop_count", 32'(bus.count), 32'd4);
    chk("fullpop_pc",    bus.imem_addr, 32'd5);
    chk("fullpop_head",  bus.instr_out, C_BASE + 1);
    step(2);
    chk("fullhold_head", bus.instr_out, C_BASE + 1);
    chk("fullhold_pc",   bus.imem_addr, 32'd5);
    bus.instr_ready = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      step(1);
      chk("drain_order", bus.instr_out, C_BASE + 1 + j);
    end

    // HALT at word 3
    mem[3] = 32'hF000_0000;
    bus.instr_ready = 1'b0;
    do_reset();
    step(3);
    chk("pre_halt", 32'(bus.halted), 32'd0);
    step(1);
    chk("halt_set",   32'(bus.halted), 32'd1);
    chk("halt_pc",    bus.imem_addr, 32'd4);
    chk("halt_count", 32'(bus.count), 32'd4);
    bus.instr_ready = 1'b1;
    step(1);
    chk("halt_d1", bus.instr_out, C_BASE + 1);
    chk("halt_c1", 32'(bus.count), 32'd3);
    step(1);
    chk("halt_d2", bus.instr_out, C_BASE + 2);
    step(1);
    chk("halt_d3", bus.instr_out, 32'hF000_0000);
    step(1);
    chk("halt_empty_valid", 32'(bus.instr_valid), 32'd0);
    chk("halt_empty_out",   bus.instr_out, 32'd0);
    step(2);
    chk("halt_frozen_pc",   bus.imem_addr, 32'd4);
    chk("halt_frozen_fcnt", bus.fetch_cnt, 32'd4);

    // Flush with 3 queued words while halted
    bus.instr_ready = 1'b0;
    do_reset();
    step(4);
    bus.instr_ready = 1'b1;
    step(1);
    bus.instr_ready = 1'b0;
    chk("pf_count",  32'(bus.count), 32'd3);
    chk("pf_halted", 32'(bus.halted), 32'd1);
    bus.flush = 1'b1; bus.flush_pc = 32'h20;
    step(1);
    bus.flush = 1'b0;
    chk("fl_count",  32'(bus.count), 32'd0);
    chk("fl_halted", 32'(bus.halted), 32'd0);
    chk("fl_valid",  32'(bus.instr_valid), 32'd0);
    chk("fl_pc",     bus.imem_addr, 32'h20);
    chk("fl_fcnt",   bus.fetch_cnt, 32'd4);
    step(1);
    chk("fl_first",  bus.instr_out, C_BASE + 32'h20);
    chk("fl_fcnt2",  bus.fetch_cnt, 32'd5);

    // Mid-run reset with 2 words queued and PC = 7
    mem[3] = C_BASE + 3;
    do_reset();
    bus.instr_ready = 1'b1;
    step(6);
    bus.instr_ready = 1'b0;
    step(1);
    chk("mr_count_pre", 32'(bus.count), 32'd2);
    chk("mr_pc_pre",    bus.imem_addr, 32'd7);
    do_reset();
    chk("mr_pc",    bus.imem_addr, 32'd0);
    chk("mr_count", 32'(bus.count), 32'd0);
    chk("mr_fcnt",  bus.fetch_cnt, 32'd0);
    chk("mr_valid", 32'(bus.instr_valid), 32'd0);
    bus.instr_ready = 1'b1;
    step(1);
    chk("mr_restart", bus.instr_out, C_BASE);
    chk("mr_pc1",     bus.imem_addr, 32'd1);

    // PCEn low: pops continue, PC holds
    bus.PCEn = 1'b0;
    step(1);
    chk("pcen_valid", 32'(bus.instr_valid), 32'd0);
    chk("pcen_pc",    bus.imem_addr, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
